// File: rtl/long_op_scoreboard_if.sv
// D-stage <-> long-op scoreboard signal bundle.
// fwdLong1D/fwdLong2D exist only when SCOREBOARD_FWD_EN is defined.
interface long_op_scoreboard_if #(
    parameter int unsigned REG_SIZE = 5,
    parameter int unsigned NREG     = 32
);
    logic                advanceD;
    logic                longValidD;
    logic                normWriteD;
    logic [REG_SIZE-1:0] writeRegD;
    logic [REG_SIZE-1:0] raddr1D;
    logic [REG_SIZE-1:0] raddr2D;
    logic                stallScoreD;
    logic                longIssue;
    logic                longWbValidW;
    logic [REG_SIZE-1:0] longWbDstW;
    logic [NREG-1:0]     busyVec;
    logic [3:0]          inFlight;
`ifdef SCOREBOARD_FWD_EN
    logic                fwdLong1D;
    logic                fwdLong2D;

    modport master (
        output advanceD, longValidD, normWriteD, writeRegD, raddr1D, raddr2D,
        input  stallScoreD, longIssue, longWbValidW, longWbDstW, busyVec, inFlight,
        input  fwdLong1D, fwdLong2D
    );
    modport slave (
        input  advanceD, longValidD, normWriteD, writeRegD, raddr1D, raddr2D,
        output stallScoreD, longIssue, longWbValidW, longWbDstW, busyVec, inFlight,
        output fwdLong1D, fwdLong2D
    );
`else
    modport master (
        output advanceD, longValidD, normWriteD, writeRegD, raddr1D, raddr2D,
        input  stallScoreD, longIssue, longWbValidW, longWbDstW, busyVec, inFlight
    );
    modport slave (
        input  advanceD, longValidD, normWriteD, writeRegD, raddr1D, raddr2D,
        output stallScoreD, longIssue, longWbValidW, longWbDstW, busyVec, inFlight
    );
`endif
endinterface

// File: rtl/long_op_scoreboard.sv
// Issue control and busy-register scoreboard for a fixed-latency pipelined long-op unit.
// Optional completion-cycle forwarding is enabled by defining SCOREBOARD_FWD_EN.
module long_op_scoreboard #(
    parameter int unsigned REG_SIZE = 5,
    parameter int unsigned NREG     = 32,
    parameter int unsigned LAT      = 6
) (
    input logic                 clk,
    input logic                 rst_n,
    long_op_scoreboard_if.slave sb
);
    logic [LAT-1:0]               r_pipe_vld;
    logic [LAT-1:0][REG_SIZE-1:0] r_pipe_dst;
    logic [NREG-1:0]              r_busy;
    logic [3:0]                   r_in_flight;

    logic [LAT-1:0]               w_pipe_vld_d;
    logic [LAT-1:0][REG_SIZE-1:0] w_pipe_dst_d;
    logic [NREG-1:0]              w_busy_d;
    logic [3:0]                   w_in_flight_d;

    logic                w_comp_vld;
    logic [REG_SIZE-1:0] w_comp_dst;
    logic [NREG-1:0]     w_busy_eff;
    logic                w_raw1;
    logic                w_raw2;
    logic                w_waw;
    logic                w_struct;
    logic                w_stall;
    logic                w_issue;

    assign w_comp_vld = r_pipe_vld[0];
    assign w_comp_dst = r_pipe_dst[0];

    // With forwarding, the register completing this cycle no longer counts as pending.
    always_comb begin
        w_busy_eff = r_busy;
`ifdef SCOREBOARD_FWD_EN
        if (w_comp_vld) begin
            w_busy_eff[w_comp_dst] = 1'b0;
        end
`endif
    end

    assign w_raw1   = (sb.raddr1D != '0) && w_busy_eff[sb.raddr1D];
    assign w_raw2   = (sb.raddr2D != '0) && w_busy_eff[sb.raddr2D];
    assign w_waw    = (sb.longValidD || sb.normWriteD) && (sb.writeRegD != '0)
                      && w_busy_eff[sb.writeRegD];
    // A normal write leaving D now would land on pipe slot 3.
    assign w_struct = sb.normWriteD && r_pipe_vld[3];
    assign w_stall  = (w_raw1 || w_raw2 || w_waw || w_struct)
                      && (sb.longValidD || sb.normWriteD || w_raw1 || w_raw2);
    assign w_issue  = sb.longValidD && sb.advanceD && !w_stall;

    always_comb begin
        w_pipe_vld_d = '0;
        w_pipe_dst_d = '0;
        for (int unsigned i = 0; i < LAT - 1; i++) begin
            w_pipe_vld_d[i] = r_pipe_vld[i+1];
            w_pipe_dst_d[i] = r_pipe_dst[i+1];
        end
        w_pipe_vld_d[LAT-1] = w_issue;
        w_pipe_dst_d[LAT-1] = w_issue ? sb.writeRegD : '0;

        w_busy_d = r_busy;
        if (w_comp_vld) begin
            w_busy_d[w_comp_dst] = 1'b0;
        end
        if (w_issue && (sb.writeRegD != '0)) begin
            w_busy_d[sb.writeRegD] = 1'b1;
        end
        w_busy_d[0] = 1'b0;

        w_in_flight_d = r_in_flight + 4'(w_issue) - 4'(w_comp_vld);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pipe_vld  <= '0;
            r_pipe_dst  <= '0;
            r_busy      <= '0;
            r_in_flight <= '0;
        end else begin
            r_pipe_vld  <= w_pipe_vld_d;
            r_pipe_dst  <= w_pipe_dst_d;
            r_busy      <= w_busy_d;
            r_in_flight <= w_in_flight_d;
        end
    end

    assign sb.stallScoreD  = w_stall;
    assign sb.longIssue    = w_issue;
    assign sb.longWbValidW = w_comp_vld;
    assign sb.longWbDstW   = w_comp_vld ? w_comp_dst : '0;
    assign sb.busyVec      = r_busy;
    assign sb.inFlight     = r_in_flight;
`ifdef SCOREBOARD_FWD_EN
    assign sb.fwdLong1D    = (sb.raddr1D != '0) && w_comp_vld && (w_comp_dst == sb.raddr1D);
    assign sb.fwdLong2D    = (sb.raddr2D != '0) && w_comp_vld && (w_comp_dst == sb.raddr2D);
`endif
endmodule

// File: tb/tb_long_op_scoreboard.sv
// Directed plus random bench for long_op_scoreboard, checked against a list-of-ops model.
// Honors SCOREBOARD_FWD_EN when defined.
module tb_long_op_scoreboard;
    localparam int unsigned REG_SIZE = 5;
    localparam int unsigned NREG     = 32;
    localparam int unsigned LAT      = 6;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    long_op_scoreboard_if #(.REG_SIZE(REG_SIZE), .NREG(NREG)) sb_if ();

    long_op_scoreboard #(.REG_SIZE(REG_SIZE), .NREG(NREG), .LAT(LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sb    (sb_if)
    );

    // Model: every in-flight long op with its destination and writeback cycle.
    typedef struct {
        int dst;
        int due;
    } op_t;

    op_t q[$];
    int  cyc   = 0;
    int  n_cmp = 0;
    int  n_bad = 0;

`ifdef SCOREBOARD_FWD_EN
    localparam bit Fwd = 1'b1;
`else
    localparam bit Fwd = 1'b0;
`endif

    function automatic bit m_busy(int r, bit excl_comp);
        if (r == 0) return 1'b0;
        foreach (q[i]) begin
            if (q[i].dst == r && !(excl_comp && q[i].due == cyc)) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic bit m_due(int c);
        foreach (q[i]) if (q[i].due == c) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int m_comp_dst();
        foreach (q[i]) if (q[i].due == cyc) return q[i].dst;
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s cyc=%0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic step(input bit rst, input bit adv, input bit lv, input bit nw,
                        input int wr, input int r1, input int r2, input bit do_chk,
                        output bit e_issue, output bit o_stall, output int o_if);
        int         comp;
        bit         raw1, raw2, waw, st, e_stall;
        logic [31:0] e_busy;
        @(negedge clk);
        rst_n            = rst;
        sb_if.advanceD   = adv;
        sb_if.longValidD = lv;
        sb_if.normWriteD = nw;
        sb_if.writeRegD  = wr[REG_SIZE-1:0];
        sb_if.raddr1D    = r1[REG_SIZE-1:0];
        sb_if.raddr2D    = r2[REG_SIZE-1:0];
        #1;
        comp    = m_comp_dst();
        raw1    = m_busy(r1, Fwd);
        raw2    = m_busy(r2, Fwd);
        waw     = (lv || nw) && m_busy(wr, Fwd);
        st      = nw && m_due(cyc + 3);
        e_stall = (raw1 || raw2 || waw || st) && (lv || nw || raw1 || raw2);
        e_issue = lv && adv && !e_stall && rst;
        e_busy  = '0;
        for (int r = 1; r < 32; r++) e_busy[r] = m_busy(r, 1'b0);
        o_stall = sb_if.stallScoreD;
        o_if    = int'(sb_if.inFlight);
        if (do_chk) begin
            chk("stall", 32'(sb_if.stallScoreD), 32'(e_stall));
            chk("issue", 32'(sb_if.longIssue), 32'(lv && adv && !e_stall));
            chk("wb_valid", 32'(sb_if.longWbValidW), 32'(comp >= 0));
            chk("wb_dst", 32'(sb_if.longWbDstW), (comp >= 0) ? 32'(comp) : 32'd0);
            chk("busy_vec", sb_if.busyVec, e_busy);
            chk("in_flight", 32'(sb_if.inFlight), 32'(q.size()));
`ifdef SCOREBOARD_FWD_EN
            chk("fwd1", 32'(sb_if.fwdLong1D), 32'(r1 != 0 && comp == r1));
            chk("fwd2", 32'(sb_if.fwdLong2D), 32'(r2 != 0 && comp == r2));
`endif
        end
        @(posedge clk);
        if (!rst) begin
            q.delete();
        end else begin
            for (int i = q.size() - 1; i >= 0; i--) if (q[i].due == cyc) q.delete(i);
            if (e_issue) q.push_back('{dst: wr, due: cyc + int'(LAT)});
        end
        cyc++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1);
    end

    initial begin
        bit iss, s;
        int inf, cnt, peak;

        // Reset held with a long op presented; first cycle state is still unknown.
        step(0, 1, 1, 0, 5, 0, 0, 0, iss, s, inf);
        step(0, 1, 1, 0, 5, 0, 0, 1, iss, s, inf);
        step(0, 1, 1, 0, 5, 0, 0, 1, iss, s, inf);
        chk("reset_inflight", 32'(inf), 32'd0);

        // Single issue to r5, then drain to the writeback.
        step(1, 1, 1, 0, 5, 0, 0, 1, iss, s, inf);
        repeat (7) step(1, 1, 0, 0, 0, 0, 0, 1, iss, s, inf);

        // RAW: reader of r7 waits for the long op.
        step(1, 1, 1, 0, 7, 0, 0, 1, iss, s, inf);
        cnt = 0;
        for (int k = 0; k < 12; k++) begin
            step(1, 1, 0, 1, 8, 7, 0, 1, iss, s, inf);
            if (!s) break;
            cnt++;
        end
        chk("raw_stall_cycles", 32'(cnt), Fwd ? 32'd5 : 32'd6);
        repeat (3) step(1, 1, 0, 0, 0, 0, 0, 1, iss, s, inf);

        // Structural: normal write at t+3 collides with slot 3.
        step(1, 1, 1, 0, 3, 0, 0, 1, iss, s, inf);
        repeat (2) step(1, 1, 0, 0, 0, 0, 0, 1, iss, s, inf);
        cnt = 0;
        for (int k = 0; k < 6; k++) begin
            step(1, 1, 0, 1, 9, 0, 0, 1, iss, s, inf);
            if (!s) break;
            cnt++;
        end
        chk("struct_stall_cycles", 32'(cnt), 32'd1);
        repeat (5) step(1, 1, 0, 0, 0, 0, 0, 1, iss, s, inf);

        // WAW: second long op to r4 held until the first completes.
        step(1, 1, 1, 0, 4, 0, 0, 1, iss, s, inf);
        cnt  = 0;
        peak = 0;
        for (int k = 0; k < 12; k++) begin
            step(1, 1, 1, 0, 4, 0, 0, 1, iss, s, inf);
            if (inf > peak) peak = inf;
            if (!s) break;
            cnt++;
        end
        chk("waw_stall_cycles", 32'(cnt), Fwd ? 32'd5 : 32'd6);
        chk("waw_peak_inflight", 32'(peak), 32'd1);
        repeat (8) step(1, 1, 0, 0, 0, 0, 0, 1, iss, s, inf);

        // Back-to-back r1..r6, then a dst-0 op.
        peak = 0;
        for (int d = 1; d <= 6; d++) begin
            step(1, 1, 1, 0, d, 0, 0, 1, iss, s, inf);
            if (inf > peak) peak = inf;
        end
        step(1, 1, 1, 0, 0, 0, 0, 1, iss, s, inf);
        if (inf > peak) peak = inf;
        chk("b2b_peak_inflight", 32'(peak), 32'd6);
        repeat (8) step(1, 1, 0, 0, 0, 0, 0, 1, iss, s, inf);

        // Reset with three ops in flight.
        for (int d = 10; d <= 12; d++) step(1, 1, 1, 0, d, 0, 0, 1, iss, s, inf);
        step(0, 0, 0, 0, 0, 0, 0, 1, iss, s, inf);
        repeat (8) step(1, 1, 0, 0, 0, 0, 0, 1, iss, s, inf);

        // Random traffic on a small register window to provoke hazards.
        for (int k = 0; k < 600; k++) begin
            bit lv, nw;
            lv = ($urandom % 3) == 0;
            nw = !lv && (($urandom % 2) == 0);
            step(($urandom % 100) != 0, ($urandom % 4) != 0, lv, nw, int'($urandom % 8),
                 int'($urandom % 8), int'($urandom % 8), 1, iss, s, inf);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
